// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// The state encoding is fixed binary so that debug taps decode the same everywhere.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    localparam int RETRY_W = 3;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single level signal; resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock wait and lock qualification before releasing core reset;
// re-sequences on lock loss with bounded retries. Runs entirely on refclk.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               reconfig_req,
    output logic               pll_rst,
    output logic               core_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output state_e             dbg_state_o
);

    localparam int CNT_W =
        $clog2(max3(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            S_RESET: begin
                if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) >= MAX_RETRIES) ? S_FAULT : S_RESET;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                // A glitch restarts the lock wait without charging a retry.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                end
            end
            S_FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = '0;
            end
        endcase

        // Reconfig wins the state transition but never hides a lock-loss count.
        if (reconfig_req) begin
            state_d = S_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    assign pll_rst     = (state_q == S_RESET) || (state_q == S_FAULT);
    assign core_rst_n  = (state_q == S_RUN);
    assign ready       = (state_q == S_RUN);
    assign fault       = (state_q == S_FAULT);
    assign retry_cnt   = retry_q;
    assign loss_cnt    = loss_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized scoreboard bench for pll_lock_sequencer with a timeline-based reference model.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int RST_P  = 4;
    localparam int STAB_P = 8;
    localparam int TO_P   = 32;
    localparam int MAXR_P = 2;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_QUAL  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    localparam logic [14:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       reconfig_req = 1'b0;
    logic       pll_rst, core_rst_n, ready, fault;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;
    state_e     dbg_state;

    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RST_P),
        .LOCK_STABLE_CYCLES  (STAB_P),
        .LOCK_TIMEOUT_CYCLES (TO_P),
        .MAX_RETRIES         (MAXR_P)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .reconfig_req (reconfig_req),
        .pll_rst      (pll_rst),
        .core_rst_n   (core_rst_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .loss_cnt     (loss_cnt),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    always #5 refclk = ~refclk;

    function automatic logic [14:0] outs_now();
        return {pll_rst, core_rst_n, ready, fault, retry_cnt, loss_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: phases with entry timestamps; lock seen by the sequencer
    // is the raw input sampled two edges earlier.
    initial begin : ref_model
        int phase, nxt, t_enter, retries, losses, el;
        bit h1, h2, ls;
        phase = PH_PULSE; t_enter = 0; retries = 0; losses = 0; h1 = 0; h2 = 0;
        forever begin
            @(posedge refclk);
            cyc++;
            if (!rst_n) begin
                phase = PH_PULSE; t_enter = cyc; retries = 0; losses = 0; h1 = 0; h2 = 0;
            end else begin
                ls  = h2;
                el  = cyc - t_enter;
                nxt = phase;
                case (phase)
                    PH_PULSE: if (el == RST_P) nxt = PH_WAIT;
                    PH_WAIT: begin
                        if (ls) nxt = PH_QUAL;
                        else if (el == TO_P) begin
                            retries = (retries < 7) ? retries + 1 : 7;
                            nxt = (retries >= MAXR_P) ? PH_FAULT : PH_PULSE;
                        end
                    end
                    PH_QUAL: begin
                        if (!ls) nxt = PH_WAIT;
                        else if (el == STAB_P) begin
                            nxt = PH_RUN;
                            retries = 0;
                        end
                    end
                    PH_RUN: begin
                        if (!ls) begin
                            nxt = PH_PULSE;
                            losses = (losses < 255) ? losses + 1 : 255;
                        end
                    end
                    default: ;
                endcase
                if (reconfig_req) begin
                    nxt = PH_PULSE;
                    retries = 0;
                end
                if (nxt != phase || reconfig_req) t_enter = cyc;
                phase = nxt;
                h2 = h1;
                h1 = pll_locked;
            end
            exp_q.push_back({phase == PH_PULSE || phase == PH_FAULT, phase == PH_RUN,
                             phase == PH_RUN, phase == PH_FAULT, 3'(retries), 8'(losses)});
        end
    end

    // scoreboard monitor
    always @(negedge refclk) begin
        if (exp_q.size() > 0) check("sb_outputs", 32'(outs_now()), 32'(exp_q.pop_front()));
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic pulse_reconfig();
        reconfig_req = 1'b1;
        step(1);
        reconfig_req = 1'b0;
    endtask

    task automatic wait_for(input bit want_fault, input int budget, output int edges);
        edges = 0;
        while (((want_fault ? fault : ready) !== 1'b1) && edges < budget) begin
            step(1);
            edges++;
        end
        check(want_fault ? "wait_fault" : "wait_ready",
              32'(want_fault ? fault : ready), 32'd1);
    endtask

    initial begin : stimulus
        int edges;
        #1;
        check("reset_outputs", 32'(outs_now()), 32'(RESET_VEC));
        step(3);
        rst_n = 1'b1;

        // Power-up: lock from edge 10, release after edge 20.
        step(3);
        check("pll_rst_edge3", 32'(pll_rst), 32'd1);
        step(1);
        check("pll_rst_edge4", 32'(pll_rst), 32'd0);
        step(5);
        pll_locked = 1'b1;
        wait_for(1'b0, 40, edges);
        check("ready_edge", 32'(9 + edges), 32'd20);

        // Random lock activity with occasional reconfig.
        for (int r = 0; r < 40; r++) begin
            int hold;
            pll_locked = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 70);
            for (int c = 0; c < hold; c++) begin
                reconfig_req = ($urandom_range(0, 63) == 0);
                step(1);
            end
            reconfig_req = 1'b0;
        end

        // No lock: two timeouts then fault.
        pll_locked = 1'b0;
        pulse_reconfig();
        wait_for(1'b1, 200, edges);
        check("fault_retry", 32'(retry_cnt), 32'd2);
        check("fault_pll_rst", 32'(pll_rst), 32'd1);
        check("fault_core_rst", 32'(core_rst_n), 32'd0);
        step(20);
        check("fault_held", 32'(fault), 32'd1);

        // Reconfig clears fault; normal lock follows.
        pulse_reconfig();
        check("reconfig_retry", 32'(retry_cnt), 32'd0);
        check("reconfig_fault", 32'(fault), 32'd0);
        pll_locked = 1'b1;
        wait_for(1'b0, 60, edges);

        // Glitch during qualification restarts it.
        pulse_reconfig();
        step(9);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(6);
        check("glitch_core_rst", 32'(core_rst_n), 32'd0);
        wait_for(1'b0, 60, edges);

        // Repeated lock loss saturates loss_cnt.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            wait_for(1'b0, 60, edges);
        end
        check("loss_sat", 32'(loss_cnt), 32'd255);

        // Async reset mid-qualification.
        pulse_reconfig();
        step(8);
        @(negedge refclk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 32'(outs_now()), 32'(RESET_VEC));
        step(2);
        rst_n = 1'b1;
        wait_for(1'b0, 60, edges);

        // Reconfig coincident with lock loss in run.
        pll_locked = 1'b0;
        step(2);
        reconfig_req = 1'b1;
        step(1);
        reconfig_req = 1'b0;
        check("coincident_loss", 32'(loss_cnt), 32'd1);
        check("coincident_pll_rst", 32'(pll_rst), 32'd1);
        pll_locked = 1'b1;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
